uart_loader: RTL and testbench

Program loader that sequences the UART receiver's byte stream into 32-bit words and writes them into instruction memory. It sits between the UART receiver (consumes its data-valid strobe and byte) and the instruction-memory write port. While a load is in progress it holds the processor in reset. It parses a fixed frame, tracks a timeout and reports completion or error.

---
 rtl/uart_loader_pkg.sv | 31 +++
 rtl/uart_loader_timeout.sv | 29 ++
 rtl/uart_loader.sv | 198 +++++++++++++++++++
 tb/tb_uart_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM states, error codes, defaults.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_CKSUM   = 2'd2;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         TMO_W             = 20;

    // Little-endian lane insert: lane 0 lands in [7:0].
    function automatic logic [31:0] lane_insert(input logic [31:0] w,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte idle counter; expired asserts while enabled and the count equals LIMIT.
module uart_loader_timeout
    import uart_loader_pkg::*;
#(
    parameter int unsigned LIMIT = 50000
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Expired
);

    localparam logic [TMO_W-1:0] LIM = TMO_W'(LIMIT);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n)
            cnt <= '0;
        else if (i_Clr)
            cnt <= '0;
        else if (i_En)
            cnt <= cnt + TMO_W'(1);
    end

    assign o_Expired = i_En && (cnt == LIM);

endmodule

// File: rtl/uart_loader.sv
// UART byte stream -> instruction memory word loader with CPU hold, timeout and
// optional checksum byte (enabled by defining UART_LOADER_CHECKSUM_EN).
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 10,
    parameter int unsigned BASE_ADDR    = 0,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CLKS = 50000
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    input  logic                  i_Rx_DV,
    input  logic [7:0]            i_Rx_Byte,
    output logic                  o_Mem_We,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic [31:0]           o_Mem_Wdata,
    output logic                  o_Cpu_Hold,
    output logic                  o_Done,
    output logic [1:0]            o_Error
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_e ST_END = ST_CHECK;
`else
    localparam state_e ST_END = ST_DONE;
`endif

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           word_q, word_d, word_ins;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  hold_q, hold_d;
    logic [1:0]            err_q, err_d;
    logic [15:0]           len_new;
    logic                  tmo_active, tmo_expired;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    assign tmo_active = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHECK);

    uart_loader_timeout #(.LIMIT(TIMEOUT_CLKS)) u_timeout (
        .i_Clock   (i_Clock),
        .i_Rst_n   (i_Rst_n),
        .i_Clr     (i_Rx_DV || !tmo_active),
        .i_En      (tmo_active),
        .o_Expired (tmo_expired)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= BASE;
            hold_q  <= 1'b0;
            err_q   <= ERR_NONE;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // A received byte always wins over a timeout firing in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        word_d   = word_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        addr_d   = we_q ? addr_q + ADDR_WIDTH'(4) : addr_q;
        hold_d   = hold_q;
        err_d    = err_q;
        word_ins = lane_insert(word_q, idx_q, i_Rx_Byte);
        len_new  = {i_Rx_Byte, cnt_q[7:0]};
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                    state_d = ST_LEN_LO;
                    hold_d  = 1'b1;
                    err_d   = ERR_NONE;
                    addr_d  = BASE;
                    cnt_d   = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_LEN_LO: begin
                if (i_Rx_DV) begin
                    cnt_d   = {8'h00, i_Rx_Byte};
                    state_d = ST_LEN_HI;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_LEN_HI: begin
                if (i_Rx_DV) begin
                    cnt_d = len_new;
                    idx_d = '0;
                    if (len_new == 16'd0) begin
                        state_d = ST_END;
                        if (ST_END == ST_DONE)
                            hold_d = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_DATA: begin
                if (i_Rx_DV) begin
                    word_d = word_ins;
                    idx_d  = idx_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + i_Rx_Byte;
`endif
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = word_ins;
                        cnt_d   = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = ST_END;
                            if (ST_END == ST_DONE)
                                hold_d = 1'b0;
                        end
                    end
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                    err_d   = ERR_TIMEOUT;
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_Rx_DV) begin
                    if (sum_q + i_Rx_Byte == 8'h00) begin
                        state_d = ST_DONE;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CKSUM;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                    err_d   = ERR_TIMEOUT;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_Mem_We    = we_q;
    assign o_Mem_Addr  = addr_q;
    assign o_Mem_Wdata = wdata_q;
    assign o_Cpu_Hold  = hold_q;
    assign o_Done      = (state_q == ST_DONE);
    assign o_Error     = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader; checksum bytes are sent only when
// UART_LOADER_CHECKSUM_EN is defined.
module tb_uart_loader;

    localparam int          AW   = 10;
    localparam int unsigned BASE = 32'h3F8;   // last two words before wrap
    localparam int unsigned TMO  = 200;

    logic          gclk = 1'b0;
    logic          rst_n;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic [1:0]    err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;
    int done_cyc = -1;
    int n_done = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int w0, d0;

    uart_loader #(
        .ADDR_WIDTH   (AW),
        .BASE_ADDR    (BASE),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock     (gclk),
        .i_Rst_n     (rst_n),
        .i_Rx_DV     (rx_dv),
        .i_Rx_Byte   (rx_byte),
        .o_Mem_We    (mem_we),
        .o_Mem_Addr  (mem_addr),
        .o_Mem_Wdata (mem_wdata),
        .o_Cpu_Hold  (cpu_hold),
        .o_Done      (done),
        .o_Error     (err)
    );

    always #5 gclk = ~gclk;
    always @(posedge gclk) cyc <= cyc + 1;

    always @(negedge gclk) begin
        if (mem_we) begin
            wr_addr_q.push_back(32'(mem_addr));
            wr_data_q.push_back(mem_wdata);
        end
        if (done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge gclk);
        #1;
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge gclk);
        #1;
        rx_dv    = 1'b0;
        last_acc = cyc;
    endtask

    task automatic sb(input logic [7:0] b);
        send_byte(b, 2);
    endtask

    task automatic settle();
        repeat (3) @(posedge gclk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(posedge gclk);
        #1;
        chk("rst_we",    32'(mem_we),   32'd0);
        chk("rst_addr",  32'(mem_addr), BASE);
        chk("rst_wdata", mem_wdata,     32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_err",   32'(err),      32'd0);
        rst_n = 1'b1;

        // two-word load; data byte sum is 0x4C, so the checksum byte is 0xB4
        w0 = wr_data_q.size(); d0 = n_done;
        sb(8'hA5);
        chk("tw_hold_rise", 32'(cpu_hold), 32'd1);
        sb(8'h02); sb(8'h00);
        sb(8'h78); sb(8'h56); sb(8'h34); sb(8'h12);
        sb(8'hEF); sb(8'hBE); sb(8'hAD); sb(8'hDE);
`ifdef UART_LOADER_CHECKSUM_EN
        sb(8'hB4);
`endif
        settle();
        chk("tw_nwr", 32'(wr_data_q.size() - w0), 32'd2);
        if (wr_data_q.size() >= w0 + 2) begin
            chk("tw_a0", wr_addr_q[w0],     32'h3F8);
            chk("tw_d0", wr_data_q[w0],     32'h12345678);
            chk("tw_a1", wr_addr_q[w0 + 1], 32'h3FC);
            chk("tw_d1", wr_data_q[w0 + 1], 32'hDEADBEEF);
        end
        chk("tw_ndone",  32'(n_done - d0), 32'd1);
        chk("tw_done_t", 32'(done_cyc),    32'(last_acc));
        chk("tw_hold",   32'(cpu_hold),    32'd0);
        chk("tw_err",    32'(err),         32'd0);
        chk("tw_wrap",   32'(mem_addr),    32'h000);

        // noise then one-word frame (sum 0xAA, checksum 0x56)
        w0 = wr_data_q.size(); d0 = n_done;
        sb(8'h00); sb(8'hFF); sb(8'h3C);
        settle();
        chk("nz_hold", 32'(cpu_hold), 32'd0);
        sb(8'hA5); sb(8'h01); sb(8'h00);
        sb(8'h44); sb(8'h33); sb(8'h22); sb(8'h11);
`ifdef UART_LOADER_CHECKSUM_EN
        sb(8'h56);
`endif
        settle();
        chk("nz_nwr", 32'(wr_data_q.size() - w0), 32'd1);
        if (wr_data_q.size() >= w0 + 1) begin
            chk("nz_a0", wr_addr_q[w0], 32'h3F8);
            chk("nz_d0", wr_data_q[w0], 32'h11223344);
        end
        chk("nz_ndone", 32'(n_done - d0), 32'd1);

        // timeout, with a byte landing exactly on the expiry cycle first
        w0 = wr_data_q.size(); d0 = n_done;
        sb(8'hA5); sb(8'h02); sb(8'h00); sb(8'h11); sb(8'h22);
        send_byte(8'h33, TMO);
        chk("tmo_prio_err", 32'(err), 32'd0);
        repeat (TMO) @(posedge gclk);
        #1;
        chk("tmo_early", 32'(err), 32'd0);
        @(posedge gclk);
        #1;
        chk("tmo_err",   32'(err),      32'd1);
        settle();
        chk("tmo_hold",  32'(cpu_hold), 32'd1);
        chk("tmo_nwr",   32'(wr_data_q.size() - w0), 32'd0);
        chk("tmo_ndone", 32'(n_done - d0), 32'd0);

        // fresh sync after error, zero-length frame
        sb(8'hA5);
        chk("zl_err_clr", 32'(err),      32'd0);
        chk("zl_hold",    32'(cpu_hold), 32'd1);
        sb(8'h00); sb(8'h00);
`ifdef UART_LOADER_CHECKSUM_EN
        sb(8'h00);
`endif
        settle();
        chk("zl_nwr",   32'(wr_data_q.size() - w0), 32'd0);
        chk("zl_ndone", 32'(n_done - d0), 32'd1);
        chk("zl_hold0", 32'(cpu_hold), 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
        // wrong checksum: word written, error 2, no done
        w0 = wr_data_q.size(); d0 = n_done;
        sb(8'hA5); sb(8'h01); sb(8'h00);
        sb(8'h44); sb(8'h33); sb(8'h22); sb(8'h11);
        sb(8'h57);
        settle();
        chk("ck_nwr",   32'(wr_data_q.size() - w0), 32'd1);
        chk("ck_err",   32'(err),      32'd2);
        chk("ck_ndone", 32'(n_done - d0), 32'd0);
        chk("ck_hold",  32'(cpu_hold), 32'd1);
`endif

        // reset in the middle of DATA
        w0 = wr_data_q.size();
        sb(8'hA5); sb(8'h01); sb(8'h00); sb(8'h44); sb(8'h33);
        rst_n = 1'b0;
        #1;
        chk("mr_hold",  32'(cpu_hold), 32'd0);
        chk("mr_addr",  32'(mem_addr), BASE);
        chk("mr_wdata", mem_wdata,     32'd0);
        chk("mr_err",   32'(err),      32'd0);
        chk("mr_we",    32'(mem_we),   32'd0);
        repeat (2) @(posedge gclk);
        #1;
        rst_n = 1'b1;
        w0 = wr_data_q.size(); d0 = n_done;
        sb(8'hA5); sb(8'h01); sb(8'h00);
        sb(8'h04); sb(8'h03); sb(8'h02); sb(8'h01);
`ifdef UART_LOADER_CHECKSUM_EN
        sb(8'hF6);
`endif
        settle();
        chk("mr_nwr", 32'(wr_data_q.size() - w0), 32'd1);
        if (wr_data_q.size() >= w0 + 1) begin
            chk("mr_a0", wr_addr_q[w0], 32'h3F8);
            chk("mr_d0", wr_data_q[w0], 32'h01020304);
        end
        chk("mr_ndone", 32'(n_done - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
